// File: rtl/updown_counter_ctrl.sv
// updown_counter_ctrl: STOP/RUN/CLEAR control FSM, tick prescaler and a
// 0..MAX_COUNT up/down counter driven by single-cycle button pulses.
// Optional build macro UDC_SATURATE_EN: stop at the bounds instead of wrapping.
// All outputs are registered; asynchronous active-high reset.

module updown_counter_ctrl #(
    parameter int unsigned TICK_DIV  = 10_000_000,
    parameter int unsigned MAX_COUNT = 9999,
    localparam int unsigned CW       = $clog2(MAX_COUNT + 1)
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          i_btn_run,
    input  logic          i_btn_clear,
    input  logic          i_btn_mode,
    output logic [CW-1:0] o_count,
    output logic          o_run,
    output logic          o_down,
    output logic          o_tick
);

    localparam int unsigned PW = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PreLast = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] MaxVal  = CW'(MAX_COUNT);

    typedef enum logic [1:0] {
        StStop,
        StRun,
        StClear
    } state_e;

    state_e        state_q;
    logic [PW-1:0] presc_q;
    logic [CW-1:0] count_q;
    logic          run_q;
    logic          down_q;
    logic          tick_q;

    logic          at_last;
    logic          at_bound;
    logic [CW-1:0] count_next;

    // Step decode and next count value in the current direction (wrapping).
    always_comb begin
        at_last    = (presc_q == PreLast);
        at_bound   = down_q ? (count_q == '0) : (count_q == MaxVal);
        count_next = count_q;
        if (down_q) begin
            count_next = at_bound ? MaxVal : (count_q - CW'(1));
        end else begin
            count_next = at_bound ? '0 : (count_q + CW'(1));
        end
    end

    // Control FSM with prescaler, counter and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StStop;
            presc_q <= '0;
            count_q <= '0;
            run_q   <= 1'b0;
            down_q  <= 1'b0;
            tick_q  <= 1'b0;
        end else begin
            tick_q <= 1'b0;
            // Direction toggles in every state; a step on this edge still
            // uses the old direction because count_next reads down_q.
            if (i_btn_mode) begin
                down_q <= ~down_q;
            end
            case (state_q)
                StStop: begin
                    // Clear has priority over run when both arrive together.
                    if (i_btn_clear) begin
                        state_q <= StClear;
                        run_q   <= 1'b0;
                    end else if (i_btn_run) begin
                        state_q <= StRun;
                        run_q   <= 1'b1;
                    end
                end
                StRun: begin
                    if (at_last) begin
                        presc_q <= '0;
`ifdef UDC_SATURATE_EN
                        if (at_bound) begin
                            state_q <= StStop;
                            run_q   <= 1'b0;
                        end else begin
                            count_q <= count_next;
                            tick_q  <= 1'b1;
                        end
`else
                        count_q <= count_next;
                        tick_q  <= 1'b1;
`endif
                    end else begin
                        presc_q <= presc_q + PW'(1);
                    end
                    // Clear is ignored while running.
                    if (i_btn_run) begin
                        state_q <= StStop;
                        run_q   <= 1'b0;
                    end
                end
                StClear: begin
                    count_q <= '0;
                    presc_q <= '0;
                    state_q <= StStop;
                    run_q   <= 1'b0;
                end
                default: begin
                    state_q <= StStop;
                    run_q   <= 1'b0;
                end
            endcase
        end
    end

    assign o_count = count_q;
    assign o_run   = run_q;
    assign o_down  = down_q;
    assign o_tick  = tick_q;

endmodule
